axi_csr_fifo: RTL and testbench

- Single-clock synchronous FIFO with a direct streaming push/pop port.
- An AXI4-Lite slave CSR port (single-beat, with wlast/rlast sidebands) controls the FIFO, reports its status and gives a second push/pop path.
- Sits between a CSR manager on the csr_* bus and a local producer/consumer datapath.

---
 rtl/axi_csr_fifo_pkg.sv | 22 ++
 rtl/sync_fifo_core.sv | 59 +++++
 rtl/axi_csr_fifo.sv | 189 ++++++++++++++++++
 tb/tb_axi_csr_fifo.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_csr_fifo_pkg.sv
// axi_csr_fifo_pkg
// Shared constants for the CSR-controlled FIFO: register byte offsets,
// AXI response codes and the bit positions inside CTRL and STATUS.
package axi_csr_fifo_pkg;

  localparam logic [7:0] REG_CTRL   = 8'h00;
  localparam logic [7:0] REG_STATUS = 8'h04;
  localparam logic [7:0] REG_COUNT  = 8'h08;
  localparam logic [7:0] REG_DATA   = 8'h0C;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int CTRL_EN_BIT    = 0;
  localparam int CTRL_FLUSH_BIT = 1;

  localparam int STAT_EMPTY = 0;
  localparam int STAT_FULL  = 1;
  localparam int STAT_OVF   = 2;
  localparam int STAT_UNF   = 3;

endpackage

// File: rtl/sync_fifo_core.sv
// sync_fifo_core
// Storage, pointers and occupancy for a single-clock FIFO with one push
// and one pop interface. Callers qualify push/pop against full/empty;
// flush clears both pointers and overrides any same-cycle push or pop.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   flush         empty the FIFO on this edge
//   push, push_data  write one entry
//   pop           advance the read pointer
//   head_data     entry at the read pointer (valid when !empty)
//   full, empty, count  occupancy status, count in 0..FIFO_DEPTH
module sync_fifo_core
  import axi_csr_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16,
  localparam int PTR_W     = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic                  full,
  output logic                  empty,
  output logic [PTR_W-1:0]      count
);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wptr;
  logic [PTR_W-1:0]      rptr;

  // Extra MSB distinguishes full from empty when the index bits match.
  assign empty     = (wptr == rptr);
  assign full      = (wptr[PTR_W-1] != rptr[PTR_W-1]) &&
                     (wptr[PTR_W-2:0] == rptr[PTR_W-2:0]);
  assign count     = wptr - rptr;
  assign head_data = mem[rptr[PTR_W-2:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wptr[PTR_W-2:0]] <= push_data;
  end

endmodule

// File: rtl/axi_csr_fifo.sv
// axi_csr_fifo
// FIFO with a direct streaming push/pop port and an AXI4-Lite CSR slave
// that controls it, reports status and offers a second push/pop path.
// Ports:
//   csr_clk, csr_rst          clock, synchronous active-high reset
//   csr_aw*/csr_w*/csr_b*     AXI-Lite write channels (wlast ignored)
//   csr_ar*/csr_r*            AXI-Lite read channels (rlast = rvalid)
//   write_enable, write_data  direct push
//   read_enable, read_data    direct pop, read_data registered
// Registers: CTRL 0x00 (en, flush), STATUS 0x04 (empty, full, ovf, unf),
// COUNT 0x08, DATA 0x0C (write pushes, read pops).
module axi_csr_fifo
  import axi_csr_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  csr_clk,
  input  logic                  csr_rst,
  input  logic [ADDR_WIDTH-1:0] csr_awaddr,
  input  logic                  csr_awvalid,
  output logic                  csr_awready,
  input  logic [DATA_WIDTH-1:0] csr_wdata,
  input  logic                  csr_wvalid,
  output logic                  csr_wready,
  input  logic                  csr_wlast,
  output logic [1:0]            csr_bresp,
  output logic                  csr_bvalid,
  input  logic                  csr_bready,
  input  logic [ADDR_WIDTH-1:0] csr_araddr,
  input  logic                  csr_arvalid,
  output logic                  csr_arready,
  output logic [DATA_WIDTH-1:0] csr_rdata,
  output logic [1:0]            csr_rresp,
  output logic                  csr_rvalid,
  input  logic                  csr_rready,
  output logic                  csr_rlast,
  input  logic                  write_enable,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  read_enable,
  output logic [DATA_WIDTH-1:0] read_data
);

  localparam int PTR_W = $clog2(FIFO_DEPTH) + 1;

  logic                  ctrl_en;
  logic                  ovf_flag;
  logic                  unf_flag;
  logic                  full;
  logic                  empty;
  logic [PTR_W-1:0]      count;
  logic [DATA_WIDTH-1:0] head_data;

  logic aw_hit_ctrl, aw_hit_status, aw_hit_count, aw_hit_data;
  logic ar_hit_ctrl, ar_hit_status, ar_hit_count, ar_hit_data;
  logic wr_acc, rd_acc;
  logic dir_push_req, dir_pop_req, axi_push_req, axi_pop_req;
  logic push_req, pop_req, push_ok, pop_ok, flush;
  logic [DATA_WIDTH-1:0] push_data;
  logic [1:0]            wr_resp;
  logic [DATA_WIDTH-1:0] rd_data_nxt;
  logic [1:0]            rd_resp_nxt;
  logic                  unused_sigs;

  assign unused_sigs = &{1'b0, csr_wlast};

  assign aw_hit_ctrl   = (csr_awaddr == ADDR_WIDTH'(REG_CTRL));
  assign aw_hit_status = (csr_awaddr == ADDR_WIDTH'(REG_STATUS));
  assign aw_hit_count  = (csr_awaddr == ADDR_WIDTH'(REG_COUNT));
  assign aw_hit_data   = (csr_awaddr == ADDR_WIDTH'(REG_DATA));
  assign ar_hit_ctrl   = (csr_araddr == ADDR_WIDTH'(REG_CTRL));
  assign ar_hit_status = (csr_araddr == ADDR_WIDTH'(REG_STATUS));
  assign ar_hit_count  = (csr_araddr == ADDR_WIDTH'(REG_COUNT));
  assign ar_hit_data   = (csr_araddr == ADDR_WIDTH'(REG_DATA));

  assign dir_push_req = ctrl_en && write_enable;
  assign dir_pop_req  = ctrl_en && read_enable;

  // A DATA access from AXI stalls while the direct port wants the same
  // operation, so at most one push source and one pop source per cycle.
  assign wr_acc = !csr_rst && csr_awvalid && csr_wvalid && !csr_bvalid &&
                  !(aw_hit_data && dir_push_req);
  assign rd_acc = !csr_rst && csr_arvalid && !csr_rvalid &&
                  !(ar_hit_data && dir_pop_req);

  assign csr_awready = wr_acc;
  assign csr_wready  = wr_acc;
  assign csr_arready = rd_acc;
  assign csr_rlast   = csr_rvalid;

  assign flush        = wr_acc && aw_hit_ctrl && csr_wdata[CTRL_FLUSH_BIT];
  assign axi_push_req = wr_acc && aw_hit_data;
  assign axi_pop_req  = rd_acc && ar_hit_data;
  assign push_req     = dir_push_req || axi_push_req;
  assign pop_req      = dir_pop_req || axi_pop_req;

  // Flush swallows same-cycle traffic silently: nothing moves, no flags.
  assign pop_ok    = pop_req && !empty && !flush;
  assign push_ok   = push_req && (!full || pop_ok) && !flush;
  assign push_data = axi_push_req ? csr_wdata : write_data;

  sync_fifo_core #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_core (
    .clk       (csr_clk),
    .rst       (csr_rst),
    .flush     (flush),
    .push      (push_ok),
    .push_data (push_data),
    .pop       (pop_ok),
    .head_data (head_data),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  always_comb begin
    wr_resp = RESP_OKAY;
    if (!(aw_hit_ctrl || aw_hit_status || aw_hit_data)) wr_resp = RESP_SLVERR;
    else if (aw_hit_data && !push_ok)                   wr_resp = RESP_SLVERR;
  end

  always_comb begin
    rd_data_nxt = '0;
    rd_resp_nxt = RESP_OKAY;
    if (ar_hit_ctrl) begin
      rd_data_nxt[CTRL_EN_BIT] = ctrl_en;
    end else if (ar_hit_status) begin
      rd_data_nxt[STAT_EMPTY] = empty;
      rd_data_nxt[STAT_FULL]  = full;
      rd_data_nxt[STAT_OVF]   = ovf_flag;
      rd_data_nxt[STAT_UNF]   = unf_flag;
    end else if (ar_hit_count) begin
      rd_data_nxt = DATA_WIDTH'(count);
    end else if (ar_hit_data) begin
      if (pop_ok) rd_data_nxt = head_data;
      else        rd_resp_nxt = RESP_SLVERR;
    end else begin
      rd_resp_nxt = RESP_SLVERR;
    end
  end

  always_ff @(posedge csr_clk) begin
    if (csr_rst) begin
      ctrl_en    <= 1'b1;
      ovf_flag   <= 1'b0;
      unf_flag   <= 1'b0;
      read_data  <= '0;
      csr_bvalid <= 1'b0;
      csr_bresp  <= RESP_OKAY;
      csr_rvalid <= 1'b0;
      csr_rresp  <= RESP_OKAY;
      csr_rdata  <= '0;
    end else begin
      if (wr_acc && aw_hit_ctrl) ctrl_en <= csr_wdata[CTRL_EN_BIT];

      // A new error event wins over a same-cycle W1C.
      if (push_req && !push_ok && !flush)
        ovf_flag <= 1'b1;
      else if (wr_acc && aw_hit_status && csr_wdata[STAT_OVF])
        ovf_flag <= 1'b0;

      if (pop_req && empty && !flush)
        unf_flag <= 1'b1;
      else if (wr_acc && aw_hit_status && csr_wdata[STAT_UNF])
        unf_flag <= 1'b0;

      if (dir_pop_req && pop_ok) read_data <= head_data;

      if (wr_acc) begin
        csr_bvalid <= 1'b1;
        csr_bresp  <= wr_resp;
      end else if (csr_bready) begin
        csr_bvalid <= 1'b0;
      end

      if (rd_acc) begin
        csr_rvalid <= 1'b1;
        csr_rdata  <= rd_data_nxt;
        csr_rresp  <= rd_resp_nxt;
      end else if (csr_rready) begin
        csr_rvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axi_csr_fifo.sv
module tb_axi_csr_fifo;

  localparam int DW    = 8;
  localparam int AW    = 8;
  localparam int DEPTH = 16;

  logic          csr_clk;
  logic          csr_rst;
  logic [AW-1:0] csr_awaddr;
  logic          csr_awvalid;
  logic          csr_awready;
  logic [DW-1:0] csr_wdata;
  logic          csr_wvalid;
  logic          csr_wready;
  logic          csr_wlast;
  logic [1:0]    csr_bresp;
  logic          csr_bvalid;
  logic          csr_bready;
  logic [AW-1:0] csr_araddr;
  logic          csr_arvalid;
  logic          csr_arready;
  logic [DW-1:0] csr_rdata;
  logic [1:0]    csr_rresp;
  logic          csr_rvalid;
  logic          csr_rready;
  logic          csr_rlast;
  logic          write_enable;
  logic [DW-1:0] write_data;
  logic          read_enable;
  logic [DW-1:0] read_data;

  axi_csr_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH)) dut (
    .csr_clk(csr_clk), .csr_rst(csr_rst),
    .csr_awaddr(csr_awaddr), .csr_awvalid(csr_awvalid), .csr_awready(csr_awready),
    .csr_wdata(csr_wdata), .csr_wvalid(csr_wvalid), .csr_wready(csr_wready),
    .csr_wlast(csr_wlast), .csr_bresp(csr_bresp), .csr_bvalid(csr_bvalid),
    .csr_bready(csr_bready), .csr_araddr(csr_araddr), .csr_arvalid(csr_arvalid),
    .csr_arready(csr_arready), .csr_rdata(csr_rdata), .csr_rresp(csr_rresp),
    .csr_rvalid(csr_rvalid), .csr_rready(csr_rready), .csr_rlast(csr_rlast),
    .write_enable(write_enable), .write_data(write_data),
    .read_enable(read_enable), .read_data(read_data)
  );

  initial csr_clk = 1'b0;
  always #5 csr_clk = ~csr_clk;

  int checks = 0;
  int errors = 0;

  // Reference model: contents as a queue plus the CSR-visible state.
  logic [DW-1:0] q[$];
  logic          m_en;
  logic          m_ovf;
  logic          m_unf;
  logic [DW-1:0] m_rd;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] m_status();
    return {4'b0, m_unf, m_ovf, (q.size() == DEPTH), (q.size() == 0)};
  endfunction

  task automatic m_dir(input logic we, input logic [DW-1:0] wd, input logic re);
    logic popped;
    popped = 1'b0;
    if (m_en) begin
      if (re) begin
        if (q.size() > 0) begin
          m_rd = q.pop_front();
          popped = 1'b1;
        end else m_unf = 1'b1;
      end
      if (we) begin
        if (q.size() < DEPTH) q.push_back(wd);
        else m_ovf = 1'b1;
      end
    end
  endtask

  task automatic m_axi_write(input logic [7:0] a, input logic [7:0] d, output logic [1:0] resp);
    resp = 2'b00;
    case (a)
      8'h00: begin m_en = d[0]; if (d[1]) q.delete(); end
      8'h04: begin if (d[2]) m_ovf = 1'b0; if (d[3]) m_unf = 1'b0; end
      8'h0C: begin
        if (q.size() < DEPTH) q.push_back(d);
        else begin m_ovf = 1'b1; resp = 2'b10; end
      end
      default: resp = 2'b10;
    endcase
  endtask

  task automatic m_axi_read(input logic [7:0] a, output logic [7:0] d, output logic [1:0] resp);
    d = 8'h00;
    resp = 2'b00;
    case (a)
      8'h00: d = {7'b0, m_en};
      8'h04: d = m_status();
      8'h08: d = 8'(q.size());
      8'h0C: begin
        if (q.size() > 0) d = q.pop_front();
        else begin m_unf = 1'b1; resp = 2'b10; end
      end
      default: resp = 2'b10;
    endcase
  endtask

  // All tasks start and end at a falling edge.
  task automatic tick_dir(input logic we, input logic [DW-1:0] wd, input logic re);
    write_enable = we;
    write_data   = wd;
    read_enable  = re;
    @(posedge csr_clk);
    m_dir(we, wd, re);
    @(negedge csr_clk);
    write_enable = 1'b0;
    read_enable  = 1'b0;
    check("read_data", read_data, m_rd);
  endtask

  task automatic b_handshake(input string tag, input logic [1:0] exp);
    @(negedge csr_clk);
    check({tag, "_bvalid"}, csr_bvalid, 1);
    check({tag, "_bresp"}, csr_bresp, exp);
    csr_bready = 1'b1;
    @(posedge csr_clk);
    #1 csr_bready = 1'b0;
    @(negedge csr_clk);
    check({tag, "_bvalid_clr"}, csr_bvalid, 0);
  endtask

  task automatic axi_write(input logic [7:0] a, input logic [7:0] d, input string tag);
    logic [1:0] exp;
    int n;
    csr_awaddr  = a;
    csr_wdata   = d;
    csr_awvalid = 1'b1;
    csr_wvalid  = 1'b1;
    n = 0;
    #1;
    while (!(csr_awready && csr_wready) && n < 20) begin
      @(negedge csr_clk);
      #1;
      n++;
    end
    check({tag, "_awready"}, csr_awready && csr_wready, 1);
    @(posedge csr_clk);
    m_axi_write(a, d, exp);
    #1;
    csr_awvalid = 1'b0;
    csr_wvalid  = 1'b0;
    b_handshake(tag, exp);
  endtask

  task automatic axi_read(input logic [7:0] a, input string tag);
    logic [7:0] ed;
    logic [1:0] er;
    int n;
    csr_araddr  = a;
    csr_arvalid = 1'b1;
    n = 0;
    #1;
    while (!csr_arready && n < 20) begin
      @(negedge csr_clk);
      #1;
      n++;
    end
    check({tag, "_arready"}, csr_arready, 1);
    @(posedge csr_clk);
    m_axi_read(a, ed, er);
    #1 csr_arvalid = 1'b0;
    @(negedge csr_clk);
    check({tag, "_rvalid_rlast"}, {csr_rvalid, csr_rlast}, 2'b11);
    check({tag, "_rdata"}, csr_rdata, ed);
    check({tag, "_rresp"}, csr_rresp, er);
    csr_rready = 1'b1;
    @(posedge csr_clk);
    #1 csr_rready = 1'b0;
    @(negedge csr_clk);
    check({tag, "_rvalid_clr"}, csr_rvalid, 0);
  endtask

  initial begin
    logic [1:0] exp;
    int pw, pr;
    csr_rst = 1'b1;
    csr_awaddr = '0; csr_awvalid = 1'b0; csr_wdata = '0; csr_wvalid = 1'b0;
    csr_wlast = 1'b1; csr_bready = 1'b0; csr_araddr = '0; csr_arvalid = 1'b0;
    csr_rready = 1'b0; write_enable = 1'b0; write_data = '0; read_enable = 1'b0;
    q.delete();
    m_en = 1'b1; m_ovf = 1'b0; m_unf = 1'b0; m_rd = '0;

    repeat (3) @(posedge csr_clk);
    @(negedge csr_clk);
    check("rst_ready", {csr_awready, csr_wready, csr_arready}, 3'b000);
    check("rst_valid", {csr_bvalid, csr_rvalid, csr_rlast}, 3'b000);
    check("rst_resp", {csr_bresp, csr_rresp}, 4'b0000);
    check("rst_rdata", csr_rdata, 0);
    check("rst_read_data", read_data, 0);
    csr_rst = 1'b0;
    @(negedge csr_clk);

    axi_read(8'h04, "status_rst");
    axi_read(8'h08, "count_rst");
    axi_read(8'h00, "ctrl_rst");

    for (int i = 0; i < 16; i++) tick_dir(1'b1, 8'(8'h11 + i), 1'b0);
    tick_dir(1'b1, 8'h99, 1'b0);
    axi_read(8'h08, "count_full");
    axi_read(8'h04, "status_full");
    axi_write(8'h0C, 8'hA5, "data_wr_full");

    for (int i = 0; i < 16; i++) tick_dir(1'b0, 8'h00, 1'b1);
    check("drained_last", read_data, 8'h20);
    tick_dir(1'b0, 8'h00, 1'b1);

    axi_write(8'h04, 8'h04, "clr_ovf");
    axi_read(8'h0C, "data_rd_empty");
    axi_read(8'h04, "status_unf");
    axi_write(8'h04, 8'h0C, "clr_all");
    axi_read(8'h04, "status_clr");

    // AXI DATA write blocked while the direct port pushes.
    write_enable = 1'b1;
    write_data   = 8'h31;
    csr_awaddr   = 8'h0C;
    csr_wdata    = 8'h5A;
    csr_awvalid  = 1'b1;
    csr_wvalid   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 check("stall_awready", {csr_awready, csr_wready}, 2'b00);
      @(posedge csr_clk);
      m_dir(1'b1, write_data, 1'b0);
      @(negedge csr_clk);
      write_data = write_data + 8'h01;
    end
    write_enable = 1'b0;
    #1 check("unstall_awready", {csr_awready, csr_wready}, 2'b11);
    @(posedge csr_clk);
    m_axi_write(8'h0C, 8'h5A, exp);
    #1;
    csr_awvalid = 1'b0;
    csr_wvalid  = 1'b0;
    b_handshake("stall_wr", exp);
    axi_read(8'h08, "count_stall");
    for (int i = 0; i < 4; i++) tick_dir(1'b0, 8'h00, 1'b1);
    check("order_last", read_data, 8'h5A);

    // Randomised direct traffic: push-heavy, then pop-heavy.
    for (int i = 0; i < 300; i++) begin
      pw = (i < 150) ? 70 : 30;
      pr = (i < 150) ? 30 : 70;
      tick_dir($urandom_range(0, 99) < pw, 8'($urandom), $urandom_range(0, 99) < pr);
    end
    axi_read(8'h08, "count_rand");
    axi_read(8'h04, "status_rand");
    axi_write(8'h04, 8'h0C, "clr_rand");

    // Disabled direct port must do nothing.
    axi_write(8'h00, 8'h00, "ctrl_dis");
    tick_dir(1'b1, 8'h77, 1'b1);
    tick_dir(1'b0, 8'h00, 1'b1);
    axi_read(8'h04, "status_dis");
    axi_read(8'h08, "count_dis");
    axi_write(8'h00, 8'h01, "ctrl_en");

    // Flush.
    for (int i = 0; i < 5; i++) tick_dir(1'b1, 8'($urandom), 1'b0);
    axi_read(8'h08, "count_pre_flush");
    axi_write(8'h00, 8'h03, "ctrl_flush");
    axi_read(8'h08, "count_flush");
    axi_read(8'h04, "status_flush");
    axi_read(8'h00, "ctrl_selfclr");

    axi_read(8'h40, "rd_unmapped");
    axi_write(8'h40, 8'h12, "wr_unmapped");
    axi_write(8'h08, 8'h12, "wr_count");
    axi_read(8'h08, "count_after_wr");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
